// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder. Two WIDTH-bit unsigned operands and a carry-in are
//   accepted in IDLE and added LSB-first, one bit per clock, through a single
//   full-adder cell and a carry flip-flop. The WIDTH-bit sum and the carry-out
//   are then held in DONE until the consumer takes them.
//
//   Handshakes (both sides): a transfer happens on a rising edge where valid
//   and ready are both high. in_ready is high only in IDLE, so in_valid seen in
//   any other state is ignored. out_valid is high only in DONE, so out_ready
//   seen in any other state is ignored. Operands are captured on the accept
//   edge and may change freely afterwards. There is no DONE->IDLE bypass, so
//   back-to-back operations are issued at most once every WIDTH+2 cycles.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : a/b/cin valid this cycle
//   in_ready   : block can accept operands (IDLE)
//   a, b       : WIDTH-bit unsigned operands
//   cin        : carry-in
//   out_valid  : sum/cout valid (DONE)
//   out_ready  : consumer takes result this cycle
//   sum        : (a+b+cin) mod 2^WIDTH
//   cout       : bit WIDTH of a+b+cin
//   busy       : high in RUN or DONE
//   dbg_state  : current FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_sum_shift;

  // Single full-adder cell on the current LSBs.
  assign w_s          = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry_next = (r_a_sh[0] & r_b_sh[0]) |
                        (r_a_sh[0] & r_carry)   |
                        (r_b_sh[0] & r_carry);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  // Written as shift-then-overwrite so WIDTH=1 needs no special slice.
  always_comb begin
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_carry <= w_carry_next;
          r_sum   <= w_sum_shift;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_cout  <= w_carry_next;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed and random checks of serial_adder at WIDTH=8 (d8) and WIDTH=1
//   (d1). Expected values are hand-computed constants or a+b+cin computed here.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 DUT ----------------
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       out_valid8;
  logic       out_ready8 = 1'b0;
  logic [7:0] sum8;
  logic       cout8;
  logic       busy8;
  logic [1:0] st8;

  serial_adder #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8), .dbg_state(st8)
  );

  // ---------------- WIDTH=1 DUT ----------------
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic [0:0] sum1;
  logic       cout1;
  logic       busy1;
  logic [1:0] st1;

  serial_adder #(.WIDTH(1)) d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1), .dbg_state(st1)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid on d8; lat = edges after the accept edge.
  task automatic wait_done8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid8) begin
      checks++; errors++;
      $display("FAIL wait_done8 timeout: out_valid=%0b required 1", out_valid8);
    end
  endtask

  // Full operation on d8 with immediate out_ready; returns {cout,sum}.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     output logic [8:0] res, output int lat);
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL op8_in_ready: got %0b required 1", in_ready8);
    end
    in_valid8 = 1'b1; a8 = a; b8 = b; cin8 = ci;
    tick();
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    wait_done8(lat);
    res = {cout8, sum8};
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  task automatic op1(input logic a, input logic b, input logic ci,
                     output logic [1:0] res, output int lat);
    in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = ci;
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 40) begin
      tick();
      lat++;
    end
    res = {cout1, sum1};
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if ({in_ready8, out_valid8, busy8, st8} !== 5'b1_0_0_00) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%0b vld=%0b busy=%0b st=%0d required 1 0 0 0",
               in_ready8, out_valid8, busy8, st8);
    end
    checks++;
    if ({cout8, sum8} !== 9'h000) begin
      errors++;
      $display("FAIL reset_data: got cout=%0b sum=%0h required 0 0", cout8, sum8);
    end
    checks++;
    if ({in_ready1, out_valid1, busy1, cout1, sum1} !== 5'b1_0_0_0_0) begin
      errors++;
      $display("FAIL reset_w1: got rdy=%0b vld=%0b busy=%0b cout=%0b sum=%0b required 1 0 0 0 0",
               in_ready1, out_valid1, busy1, cout1, sum1);
    end
  endtask

  task automatic test_basic();
    logic [8:0] res;
    int lat;
    op8(8'd3, 8'd5, 1'b0, res, lat);
    checks++;
    if (res !== 9'h008) begin
      errors++;
      $display("FAIL basic_3p5: got %0h required 008", res);
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges required 8", lat);
    end
    op8(8'd100, 8'd27, 1'b1, res, lat);
    checks++;
    if (res !== 9'd128) begin
      errors++;
      $display("FAIL basic_100p27p1: got %0d required 128", res);
    end
  endtask

  task automatic test_boundary();
    logic [8:0] res;
    int lat;
    op8(8'hFF, 8'h01, 1'b0, res, lat);
    checks++;
    if (res !== 9'h100) begin
      errors++;
      $display("FAIL wrap_ff_01: got %0h required 100", res);
    end
    op8(8'hFF, 8'hFF, 1'b1, res, lat);
    checks++;
    if (res !== 9'h1FF) begin
      errors++;
      $display("FAIL allones_cin: got %0h required 1ff", res);
    end
    op8(8'h00, 8'h00, 1'b0, res, lat);
    checks++;
    if (res !== 9'h000) begin
      errors++;
      $display("FAIL zeros: got %0h required 000", res);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
      errors++;
      $display("FAIL run_flags: got busy=%0b rdy=%0b required 1 0", busy8, in_ready8);
    end
    wait_done8(lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({out_valid8, in_ready8, busy8, cout8, sum8} !== {3'b101, 9'h064}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got vld=%0b rdy=%0b busy=%0b res=%0h required 1 0 1 064",
                 i, out_valid8, in_ready8, busy8, {cout8, sum8});
      end
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    checks++;
    if ({out_valid8, in_ready8, busy8} !== 3'b010) begin
      errors++;
      $display("FAIL release: got vld=%0b rdy=%0b busy=%0b required 0 1 0",
               out_valid8, in_ready8, busy8);
    end
  endtask

  task automatic test_ignore_in_run();
    logic [8:0] res;
    int lat;
    in_valid8 = 1'b1; a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    tick(); tick();
    in_valid8 = 1'b1; a8 = 8'd1; b8 = 8'd0; cin8 = 1'b0;
    checks++;
    if (in_ready8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_rdy: got %0b required 0", in_ready8);
    end
    tick();
    in_valid8 = 1'b0;
    // out_ready pulsed in RUN must not matter either.
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    wait_done8(lat);
    checks++;
    if ({cout8, sum8} !== 9'd30) begin
      errors++;
      $display("FAIL ignore_result: got %0d required 30", {cout8, sum8});
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    op8(8'd1, 8'd0, 1'b0, res, lat);
    checks++;
    if (res !== 9'd1) begin
      errors++;
      $display("FAIL after_ignore: got %0d required 1", res);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] res;
    int lat;
    bit seen;
    in_valid8 = 1'b1; a8 = 8'd100; b8 = 8'd100; cin8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({in_ready8, out_valid8, busy8, sum8} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%0b vld=%0b busy=%0b sum=%0h required 1 0 0 00",
               in_ready8, out_valid8, busy8, sum8);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid8) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abandoned_result: got out_valid=1 required 0");
    end
    op8(8'd7, 8'd9, 1'b0, res, lat);
    checks++;
    if (res !== 9'd16) begin
      errors++;
      $display("FAIL after_reset_7p9: got %0d required 16", res);
    end
  endtask

  task automatic test_width1();
    logic [1:0] res;
    int lat;
    op1(1'b1, 1'b1, 1'b1, res, lat);
    checks++;
    if (res !== 2'b11) begin
      errors++;
      $display("FAIL w1_111: got %0b required 11", res);
    end
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL w1_latency: got %0d edges required 1", lat);
    end
    op1(1'b1, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== 2'b01) begin
      errors++;
      $display("FAIL w1_100: got %0b required 01", res);
    end
    op1(1'b0, 1'b1, 1'b1, res, lat);
    checks++;
    if (res !== 2'b10) begin
      errors++;
      $display("FAIL w1_011: got %0b required 10", res);
    end
  endtask

  task automatic test_random();
    logic [8:0] res;
    logic [8:0] exp_q[$];
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic       rc;
    logic [1:0] res1;
    int lat;
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      op8(ra, rb, rc, res, lat);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || lat != 8) begin
        errors++;
        $display("FAIL rand8_%0d: a=%0h b=%0h cin=%0b got %0h lat %0d required %0h lat 8",
                 i, ra, rb, rc, res, lat, exp);
      end
    end
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 1));
      rb = 8'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      op1(ra[0], rb[0], rc, res1, lat);
      checks++;
      if (res1 !== (2'(ra[0]) + 2'(rb[0]) + 2'(rc))) begin
        errors++;
        $display("FAIL rand1_%0d: a=%0b b=%0b cin=%0b got %0b", i, ra[0], rb[0], rc, res1);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_ignore_in_run();
    test_reset_mid_run();
    test_width1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
